// File: rtl/first_nios2_sysid_pkg.sv
// rtl/first_nios2_sysid_pkg.sv - shared states, addresses and defaults for the sysid checker
package first_nios2_sysid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd7;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1385656859;

endpackage

// File: rtl/first_nios2_system_sysid_checker.sv
// rtl/first_nios2_system_sysid_checker.sv - reads sysid ID/timestamp words and compares them to build-time values
module first_nios2_system_sysid_checker
    import first_nios2_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic        timeout,
    output logic [31:0] id_seen,
    output logic [31:0] ts_seen
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sysid_state_t state;
    sysid_state_t state_next;

    logic             first_cycle;
    logic [CNT_W-1:0] wait_cnt;
    logic             launch;
    logic             in_read;
    logic             stall_expired;
    logic             id_hit;
    logic             ts_hit;

    assign in_read       = (state == RD_ID) || (state == RD_TS);
    assign stall_expired = in_read && avm_waitrequest && (wait_cnt == CNT_LAST);
    assign id_hit        = (id_seen == EXPECTED_ID);
    assign ts_hit        = (avm_readdata == EXPECTED_TS);

    // A start pulse is honoured only when no read is in flight.
    always_comb begin
        launch = 1'b0;
        if (state == IDLE) begin
            launch = start || (AUTO_START && first_cycle);
        end else if (state == DONE) begin
            launch = start;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (launch) state_next = RD_ID;
            end
            RD_ID: begin
                if (!avm_waitrequest)   state_next = RD_TS;
                else if (stall_expired) state_next = DONE;
            end
            RD_TS: begin
                if (!avm_waitrequest || stall_expired) state_next = DONE;
            end
            DONE: begin
                if (launch) state_next = RD_ID;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        avm_read    = in_read;
        avm_address = (state == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        busy        = in_read;
        done        = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            first_cycle <= 1'b1;
            wait_cnt    <= '0;
            id_seen     <= '0;
            ts_seen     <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            match       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            first_cycle <= 1'b0;

            if (launch) begin
                wait_cnt <= '0;
                id_ok    <= 1'b0;
                ts_ok    <= 1'b0;
                match    <= 1'b0;
                timeout  <= 1'b0;
            end

            if (state == RD_ID) begin
                if (!avm_waitrequest) begin
                    id_seen  <= avm_readdata;
                    wait_cnt <= '0;
                end else if (stall_expired) begin
                    timeout  <= 1'b1;
                    id_ok    <= 1'b0;
                    ts_ok    <= 1'b0;
                    match    <= 1'b0;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end

            // The ID word is already captured here, so its verdict is known even on a stall abort.
            if (state == RD_TS) begin
                if (!avm_waitrequest) begin
                    ts_seen  <= avm_readdata;
                    id_ok    <= id_hit;
                    ts_ok    <= ts_hit;
                    match    <= id_hit && ts_hit;
                    wait_cnt <= '0;
                end else if (stall_expired) begin
                    timeout  <= 1'b1;
                    id_ok    <= id_hit;
                    ts_ok    <= 1'b0;
                    match    <= 1'b0;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule
